// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and key classification helper for the keypad entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_timer.sv
// Inactivity timer: counts enabled tick pulses and raises a registered expired flag
// once TIMEOUT_TICKS have been seen; holds until cleared.
module entry_timer #(
  parameter int unsigned TIMEOUT_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;
  logic       expired_q, expired_d;

  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (clr_i) begin
      count_d   = '0;
      expired_d = 1'b0;
    end else if (en_i && tick_i && !expired_q) begin
      count_d   = count_q + 8'd1;
      expired_d = (count_d == 8'(TIMEOUT_TICKS));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: collects NUM_DIGITS decimal keys into a binary value and
// presents it on a valid/ready handshake, with clear, enter, timeout and error handling.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned VALUE_W       = 14,
  parameter int unsigned TIMEOUT_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic               pw_valid,
  output logic [VALUE_W-1:0] pw_value,
  input  logic               pw_ready,
  output logic               busy,
  output logic [2:0]         digit_count,
  output logic               entry_error
);

  localparam logic [2:0] FULL_COUNT = 3'(NUM_DIGITS);

  state_e               state_q;
  logic [VALUE_W-1:0]   acc_q, acc_d;
  logic [VALUE_W+3:0]   acc_wide;
  logic [2:0]           cnt_q;
  logic                 pw_valid_q, busy_q, err_q;
  logic [VALUE_W-1:0]   pw_value_q;
  logic                 key_digit, key_taken, tmr_clr, tmr_en, expired;

  always_comb begin
    key_digit = key_valid && is_digit(key_code);
    key_taken = key_digit || (key_valid && (key_code == KEY_CLEAR || key_code == KEY_ENTER));
    acc_wide  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {VALUE_W'(0), key_code};
    acc_d     = acc_wide[VALUE_W-1:0];
    // Timer is frozen (neither cleared nor counting) while a value is presented.
    tmr_clr   = (state_q == IDLE) || (state_q == COLLECT && key_taken);
    tmr_en    = (state_q == COLLECT);
  end

  entry_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tick_i   (tick),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      pw_valid_q <= 1'b0;
      pw_value_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_digit) begin
            acc_q   <= VALUE_W'(key_code);
            cnt_q   <= 3'd1;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          // Key handling takes precedence over a pending timeout in the same cycle.
          if (key_digit) begin
            if (cnt_q < FULL_COUNT) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 3'd1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (key_valid && key_code == KEY_ENTER) begin
            if (cnt_q == FULL_COUNT) begin
              pw_value_q <= acc_q;
              pw_valid_q <= 1'b1;
              state_q    <= PRESENT;
            end else begin
              err_q   <= 1'b1;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (key_valid && key_code == KEY_CLEAR) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        PRESENT: begin
          if (pw_ready) begin
            pw_valid_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pw_valid    = pw_valid_q;
  assign pw_value    = pw_value_q;
  assign busy        = busy_q;
  assign digit_count = cnt_q;
  assign entry_error = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural entry model.
module tb_keypad_entry_ctrl;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          pw_ready = 1'b0;
  logic          pw_valid;
  logic [VW-1:0] pw_value;
  logic          busy;
  logic [2:0]    digit_count;
  logic          entry_error;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  bit m_collecting, m_presenting, m_pv, m_err;
  int m_ndig, m_val, m_pval, m_ticks;

  keypad_entry_ctrl #(
    .NUM_DIGITS(ND),
    .VALUE_W(VW),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pw_valid   (pw_valid),
    .pw_value   (pw_value),
    .pw_ready   (pw_ready),
    .busy       (busy),
    .digit_count(digit_count),
    .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_collecting = 0; m_presenting = 0; m_pv = 0; m_err = 0;
    m_ndig = 0; m_val = 0; m_pval = 0; m_ticks = 0;
  endtask

  task automatic model_abandon(input bit err);
    m_collecting = 0; m_val = 0; m_ndig = 0; m_ticks = 0; m_err = err;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit tk, input bit rdy);
    bit digit, taken;
    digit = kv && (kc <= 9);
    taken = kv && (kc <= 11);
    m_err = 0;
    if (m_presenting) begin
      if (rdy) begin
        m_presenting = 0; m_pv = 0; m_ndig = 0; m_val = 0;
      end
    end else if (!m_collecting) begin
      if (digit) begin
        m_collecting = 1; m_val = kc; m_ndig = 1; m_ticks = 0;
      end
    end else if (taken) begin
      m_ticks = 0;
      if (digit) begin
        if (m_ndig < ND) begin
          m_val = m_val * 10 + kc;
          m_ndig++;
        end else m_err = 1;
      end else if (kc == 11) begin
        if (m_ndig == ND) begin
          m_collecting = 0; m_presenting = 1; m_pv = 1; m_pval = m_val;
        end else model_abandon(1);
      end else model_abandon(0);
    end else if (m_ticks >= TO) begin
      model_abandon(1);
    end else if (tk) begin
      m_ticks++;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("pw_valid", int'(pw_valid), int'(m_pv));
      check("pw_value", int'(pw_value), m_pval);
      check("busy", int'(busy), int'(m_collecting | m_presenting));
      check("digit_count", int'(digit_count), m_ndig);
      check("entry_error", int'(entry_error), int'(m_err));
    end
  end

  task automatic cycle(input bit kv, input int kc, input bit tk, input bit rdy);
    key_valid = kv;
    key_code  = 4'(kc);
    tick      = tk;
    pw_ready  = rdy;
    @(posedge clk);
    if (reset) model_step(kv, kc, tk, rdy);
    #1;
  endtask

  task automatic press(input int kc);
    cycle(1'b1, kc, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pw_valid", int'(pw_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_digit_count", int'(digit_count), 0);
    check("rst_pw_value", int'(pw_value), 0);
    reset = 1'b1;
    check_en = 1'b1;

    // Full entry with a delayed consumer
    press(1); press(2); press(3); press(4); press(11);
    check("t1_valid", int'(pw_valid), 1);
    check("t1_value", int'(pw_value), 'h04D2);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 0, 1'b0, 1'b0);
      check("t1_hold", int'(pw_value), 1234);
    end
    handshake();
    check("t1_after_hs_valid", int'(pw_valid), 0);
    check("t1_after_hs_busy", int'(busy), 0);

    // Short entry rejected
    press(1); press(2); press(11);
    check("t2_err", int'(entry_error), 1);
    check("t2_count", int'(digit_count), 0);
    idle(1);
    check("t2_err_pulse", int'(entry_error), 0);

    // Timeout then 9999
    press(7);
    for (int i = 0; i < TO; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    idle(1);
    check("t3_timeout_err", int'(entry_error), 1);
    check("t3_count", int'(digit_count), 0);
    press(9); press(9); press(9); press(9); press(11);
    check("t3_value", int'(pw_value), 'h270F);
    handshake();

    // Clear, then leading zeros; then 5th digit rejected
    press(5); press(6); press(10); press(0); press(0); press(0); press(1); press(11);
    check("t4_value", int'(pw_value), 1);
    handshake();
    press(1); press(2); press(3); press(4); press(5);
    check("t4_5th_err", int'(entry_error), 1);
    press(11);
    check("t4_value2", int'(pw_value), 1234);
    handshake();

    // Key coinciding with 7th tick restarts the timer
    press(3);
    for (int i = 0; i < TO - 2; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 4, 1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    idle(1);
    check("t5_no_timeout_busy", int'(busy), 1);
    check("t5_count", int'(digit_count), 2);
    press(10);

    // Asynchronous reset while presenting
    press(1); press(2); press(3); press(4); press(11);
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", int'(pw_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_count", int'(digit_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    press(4); press(3); press(2); press(1); press(11);
    check("t6_value", int'(pw_value), 4321);
    handshake();

    // Randomized traffic with varying key density
    for (int blk = 0; blk < 6; blk++) begin
      for (int n = 0; n < 600; n++) begin
        bit kv, tk, rdy;
        int kc;
        kv  = ($urandom_range(0, 4 * blk + 1) == 0);
        kc  = ($urandom_range(0, 4) == 0) ? 11 : $urandom_range(0, 15);
        tk  = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 2) == 0);
        cycle(kv, kc, tk, rdy);
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Keypad entry sequencer sitting in front of the door controller's password input. It collects NUM_DIGITS decimal key presses and converts them to a binary value. It then presents that value with a valid/ready handshake. Also handles clear and enter keys, an inactivity timeout driven by the slow tick from the frequency divider, and entry errors.

Parameters:
NUM_DIGITS, 4, digits per password entry (1..4)
VALUE_W, 14, width of presented binary value (must hold 10^NUM_DIGITS-1)
TIMEOUT_TICKS, 8, tick pulses of inactivity before an entry is abandoned (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle slow-time enable pulse (freq divider output, edge-converted upstream)
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF ignored
pw_valid  out  1  presented value valid
pw_value  out  VALUE_W  binary password value
pw_ready  in  1  consumer accepts pw_value when pw_valid & pw_ready
busy  out  1  high in COLLECT or PRESENT
digit_count  out  3  digits accepted in current entry
entry_error  out  1  one-cycle pulse on any rejected entry

Behaviour:
- Reset (async, active-low): state IDLE, accumulator 0, digit_count 0, timer 0; all outputs 0.
- States: IDLE, COLLECT, PRESENT; registered outputs only.
- IDLE: digit key -> acc=digit, digit_count=1, timer cleared, go COLLECT. Clear/enter/ignored codes -> stay IDLE, no error.
- COLLECT, digit with digit_count<NUM_DIGITS: acc = acc*10 + digit, digit_count+1, timer cleared.
- COLLECT, digit with digit_count==NUM_DIGITS: digit dropped, entry_error pulse, acc unchanged, timer cleared.
- COLLECT, enter with digit_count==NUM_DIGITS: pw_value<=acc, pw_valid<=1, go PRESENT. Enter key at cycle N -> pw_valid high at N+1.
- COLLECT, enter with digit_count<NUM_DIGITS: entry_error pulse, acc/digit_count cleared, go IDLE.
- COLLECT, clear: acc/digit_count cleared, go IDLE, no error.
- COLLECT, ignored code: no effect, timer not cleared.
- Timeout: timer counts tick pulses in COLLECT only. When count reaches TIMEOUT_TICKS: go IDLE, clear acc/digit_count, entry_error pulse.
- Key and tick in the same cycle: an accepted key wins, timer cleared, tick not counted.
- PRESENT: pw_valid held 1 and pw_value held stable until handshake. All keys ignored. Timer frozen.
- Handshake (pw_valid & pw_ready) in cycle M: pw_valid=0, digit_count=0, acc=0, state IDLE at M+1. A key in cycle M is dropped. pw_value keeps its last value.
- pw_ready while not PRESENT: no effect.
- Arithmetic: acc*10 computed as (acc<<3)+(acc<<1) at VALUE_W+4 bits, then truncated to VALUE_W. No overflow by parameter constraint. Default max is 9999 = 0x270F.
- entry_error: exactly one cycle, registered, never in PRESENT.
- Reset asserted mid-operation: immediate return to reset values. Any presented value is discarded with no handshake.

Decomposition:
- Package keypad_pkg: key code constants (KEY_CLEAR=4'hA, KEY_ENTER=4'hB), state encoding localparams (IDLE/COLLECT/PRESENT as 2-bit values).
- One sub-module, entry_timer: tick-enabled up-counter with synchronous clear, enable and parameter TIMEOUT_TICKS. Outputs a registered expired flag. Async active-low reset.
- The FSM, accumulator and handshake stay in keypad_entry_ctrl.

Test Plan:
- Keys 1,2,3,4,enter, pw_ready=0 for 5 cycles then 1 -> pw_valid rises the cycle after enter. pw_value=1234 (0x04D2) stable throughout. pw_valid low the cycle after handshake. busy low.
- Keys 1,2,enter -> single entry_error pulse, no pw_valid, digit_count back to 0, state IDLE.
- Key 7, then 8 tick pulses with no keys -> entry_error pulse on expiry, digit_count=0. A following 9,9,9,9,enter yields pw_value=9999 (0x270F).
- Keys 5,6,clear,0,0,0,1,enter -> no error. pw_value=1. Also a 5th digit after 1,2,3,4 -> entry_error, then enter gives 1234.
- Key and tick in the same cycle at tick 7 of timeout -> no timeout. Entry continues, timer restarts from 0.
- In PRESENT with pw_valid=1, assert reset for 1 cycle -> pw_valid=0, digit_count=0, busy=0 immediately. The next entry 4,3,2,1,enter yields 4321.
